uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART byte transmitter between `NUM_REQ` byte-stream requesters, such as result dump, debug trace and status.
- Each requester offers bytes with a valid/ready handshake and marks the final byte of a packet with `req_last`.
- The scheduler grants one requester per packet, prefetches its next byte, and sequences the transmitter's `isTX`/`data`/`done` handshake so packets are never interleaved.
- It sits between the on-chip producers and the UART transmitter on the Nexys4DDR top level.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_sched_rr_arbiter.sv | 30 +++
 rtl/uart_tx_sched.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } sched_state_t;

  localparam logic [7:0] UART_HDR_BASE   = 8'hA0;
  localparam int         UART_BAUD_COUNT = 868;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester set, searching upward from last_grant+1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  int             idx;
  logic [ID_W-1:0] idx_w;

  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_grant) + i) % NUM_REQ;
      idx_w = idx[ID_W-1:0];
      if (!gnt_any && req[idx_w]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_w;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-atomic scheduler sharing one UART byte transmitter between requesters.
// Define UART_SCHED_HDR_EN to prefix every packet with header byte HDR_BASE | grant_id.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
`ifdef UART_SCHED_HDR_EN
  , parameter logic [7:0] HDR_BASE = UART_HDR_BASE
`endif
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 pkt_done,
  output sched_state_t         state_dbg
);

  // Handshake: a requester byte is consumed on the edge where the scheduler captures it;
  // req_ready is the registered 1-cycle notice of that capture, after which the requester
  // presents its next byte (or drops req_valid).

  sched_state_t        state_q, state_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic                busy_q, busy_d;
  logic                pkt_done_q, pkt_done_d;
  logic [7:0]          nxt_data_q, nxt_data_d;
  logic                nxt_last_q, nxt_last_d;
  logic                nxt_valid_q, nxt_valid_d;
  logic                last_sent_q, last_sent_d;
  logic                last_acc_q, last_acc_d;
  logic                tx_done_q, tx_done_d;
`ifdef UART_SCHED_HDR_EN
  logic                hdr_pend_q, hdr_pend_d;
`endif

  logic [ID_W-1:0]     arb_id;
  logic                arb_any;
  logic                done_rise;
  logic                prefetch;
  logic                others_valid;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [7:0]          gnt_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt_id     (arb_id),
    .gnt_any    (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    tx_en_d      = tx_en_q;
    tx_data_d    = tx_data_q;
    req_ready_d  = '0;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    pkt_done_d   = 1'b0;
    nxt_data_d   = nxt_data_q;
    nxt_last_d   = nxt_last_q;
    nxt_valid_d  = nxt_valid_q;
    last_sent_d  = last_sent_q;
    last_acc_d   = last_acc_q;
    tx_done_d    = tx_done;
`ifdef UART_SCHED_HDR_EN
    hdr_pend_d   = hdr_pend_q;
`endif

    // tx_done may sit high while tx_en is low, so only its rising edge is a completion.
    done_rise    = tx_done & ~tx_done_q;
    grant_onehot = NUM_REQ'(1) << grant_id_q;
    others_valid = |(req_valid & ~grant_onehot);
    gnt_byte     = req_data[{grant_id_q, 3'b000} +: 8];
    prefetch     = ((state_q == LOAD) || (state_q == SEND)) && !nxt_valid_q &&
                   req_valid[grant_id_q] && !last_acc_q;

    if (prefetch) begin
      req_ready_d = grant_onehot;
      nxt_data_d  = gnt_byte;
      nxt_last_d  = req_last[grant_id_q];
      nxt_valid_d = 1'b1;
      last_acc_d  = req_last[grant_id_q];
    end

    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        if (|req_valid) state_d = ARB;
      end
      ARB: begin
        if (arb_any) begin
          grant_id_d   = arb_id;
          last_grant_d = arb_id;
          busy_d       = 1'b1;
          last_sent_d  = 1'b0;
          last_acc_d   = 1'b0;
          nxt_valid_d  = 1'b0;
`ifdef UART_SCHED_HDR_EN
          hdr_pend_d   = 1'b1;
`endif
          state_d      = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef UART_SCHED_HDR_EN
        if (hdr_pend_q) begin
          tx_data_d  = HDR_BASE | 8'(grant_id_q);
          tx_en_d    = 1'b1;
          hdr_pend_d = 1'b0;
          state_d    = SEND;
        end else
`endif
        if (nxt_valid_q) begin
          tx_data_d   = nxt_data_q;
          tx_en_d     = 1'b1;
          nxt_valid_d = 1'b0;
          last_sent_d = nxt_last_q;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (done_rise) begin
          if (last_sent_q) begin
            pkt_done_d = 1'b1;
            busy_d     = 1'b0;
            tx_en_d    = 1'b0;
            state_d    = others_valid ? ARB : IDLE;
          end else if (nxt_valid_q) begin
            tx_data_d   = nxt_data_q;
            nxt_valid_d = 1'b0;
            last_sent_d = nxt_last_q;
          end else begin
            tx_en_d = 1'b0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      req_ready_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      busy_q       <= 1'b0;
      pkt_done_q   <= 1'b0;
      nxt_data_q   <= '0;
      nxt_last_q   <= 1'b0;
      nxt_valid_q  <= 1'b0;
      last_sent_q  <= 1'b0;
      last_acc_q   <= 1'b0;
      tx_done_q    <= 1'b0;
`ifdef UART_SCHED_HDR_EN
      hdr_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      req_ready_q  <= req_ready_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      pkt_done_q   <= pkt_done_d;
      nxt_data_q   <= nxt_data_d;
      nxt_last_q   <= nxt_last_d;
      nxt_valid_q  <= nxt_valid_d;
      last_sent_q  <= last_sent_d;
      last_acc_q   <= last_acc_d;
      tx_done_q    <= tx_done_d;
`ifdef UART_SCHED_HDR_EN
      hdr_pend_q   <= hdr_pend_d;
`endif
    end
  end

  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign req_ready = req_ready_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign pkt_done  = pkt_done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester queues, a byte-level transmitter model, per-scenario tasks.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int BYTE_CYC = 6;
`ifdef UART_SCHED_HDR_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_last  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_done = 1'b0;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 pkt_done;
  sched_state_t         state_dbg;

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .CLK100MHZ (clk),
    .reset_n   (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0]      src_q[NUM_REQ][$];
  logic [7:0]      rx_q[$];
  logic [ID_W-1:0] rx_gnt_q[$];
  logic [ID_W-1:0] gnt_log[$];
  logic [7:0]      exp_q[$];
  logic [ID_W-1:0] exp_gnt[$];

  int         pkt_cnt = 0, en_falls = 0, stable_viol = 0, stuck_len = 1;
  bit         m_busy = 0;
  int         m_cnt = 0, m_hold = 0;
  logic [7:0] m_cur = '0;
  logic       prev_en = 1'b0;

  // requester drivers: pop on the ready pulse, present queue head
  always @(negedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = src_q[k][0][7:0];
        req_last[k]        = src_q[k][0][8];
      end else begin
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
      end
    end
  end

  // transmitter model: latch on tx_en, BYTE_CYC cycles later raise tx_done for stuck_len cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_hold = 0; tx_done = 1'b0; prev_en = 1'b0;
    end else begin
      if (prev_en && !tx_en) en_falls++;
      prev_en = tx_en;
      if (pkt_done) begin pkt_cnt++; gnt_log.push_back(grant_id); end
      if (m_busy) begin
        if (!tx_en || tx_data !== m_cur) stable_viol++;
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 0; tx_done = 1'b1; m_hold = stuck_len; end
      end else if (tx_done) begin
        m_hold--;
        if (m_hold <= 0) tx_done = 1'b0;
      end else if (tx_en) begin
        m_cur = tx_data; m_busy = 1; m_cnt = BYTE_CYC;
        rx_q.push_back(tx_data);
        rx_gnt_q.push_back(grant_id);
      end
    end
  end

  task automatic clear_logs();
    rx_q.delete(); rx_gnt_q.delete(); gnt_log.delete(); exp_q.delete(); exp_gnt.delete();
    pkt_cnt = 0; en_falls = 0; stable_viol = 0;
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input logic last);
    src_q[k].push_back({last, b});
  endtask

  task automatic exp_pkt_start(input int k);
    exp_gnt.push_back(ID_W'(k));
`ifdef UART_SCHED_HDR_EN
    exp_q.push_back(8'hA0 | 8'(k));
`endif
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int c = 0;
    while (pkt_cnt < n && c < budget) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b want=0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    checks++; if (busy !== 1'b0 || pkt_done !== 1'b0) begin failures++; $display("FAIL reset_busy_pkt got=%b%b want=00", busy, pkt_done); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [7:0] b;
    clear_logs();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NUM_REQ; k++) begin
        b = 8'((k << 4) | (p << 1));
        push_byte(k, b, 1'b0);
        push_byte(k, b | 8'h01, 1'b1);
      end
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NUM_REQ; k++) begin
        b = 8'((k << 4) | (p << 1));
        exp_pkt_start(k);
        exp_q.push_back(b);
        exp_q.push_back(b | 8'h01);
      end
    wait_pkts(8, 3000);
    checks++; if (pkt_cnt !== 8) begin failures++; $display("FAIL fair_pkt_count got=%0d want=8", pkt_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= gnt_log.size() || gnt_log[i] !== exp_gnt[i]) begin
        failures++; $display("FAIL fair_grant_order[%0d] got=%0d want=%0d", i, (i < gnt_log.size()) ? gnt_log[i] : 2'bxx, exp_gnt[i]);
      end
    end
    checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL fair_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL fair_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (stable_viol !== 0) begin failures++; $display("FAIL fair_tx_stable violations=%0d want=0", stable_viol); end
  endtask

  task automatic test_single();
    clear_logs();
    push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
    exp_pkt_start(2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    wait_pkts(1, 500);
    checks++; if (pkt_cnt !== 1) begin failures++; $display("FAIL single_pkt_done got=%0d want=1", pkt_cnt); end
    checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL single_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
      checks++;
      if (i >= rx_gnt_q.size() || rx_gnt_q[i] !== 2'd2) begin
        failures++; $display("FAIL single_grant[%0d] got=%0d want=2", i, (i < rx_gnt_q.size()) ? rx_gnt_q[i] : 2'bxx);
      end
    end
    checks++; if (en_falls !== 1) begin failures++; $display("FAIL single_tx_en_continuous falls=%0d want=1", en_falls); end
    checks++; if (stable_viol !== 0) begin failures++; $display("FAIL single_tx_stable violations=%0d want=0", stable_viol); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_stall();
    int c = 0;
    clear_logs();
    push_byte(1, 8'h41, 1'b0);
    exp_pkt_start(1);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    while (rx_q.size() < 1 + HDR_N && c < 300) begin @(negedge clk); c++; end
    checks++; if (rx_q.size() < 1 + HDR_N) begin failures++; $display("FAIL stall_first_byte got=%0d want=%0d", rx_q.size(), 1 + HDR_N); end
    repeat (500) @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL stall_tx_en got=%b want=0", tx_en); end
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL stall_grant_busy got=%0d/%b want=1/1", grant_id, busy); end
    checks++; if (pkt_cnt !== 0) begin failures++; $display("FAIL stall_no_pkt_done got=%0d want=0", pkt_cnt); end
    push_byte(1, 8'h42, 1'b1);
    wait_pkts(1, 300);
    checks++; if (pkt_cnt !== 1) begin failures++; $display("FAIL stall_resume_pkt got=%0d want=1", pkt_cnt); end
    checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL stall_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL stall_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (en_falls !== 2) begin failures++; $display("FAIL stall_tx_en_falls got=%0d want=2", en_falls); end
  endtask

  task automatic test_stuck_done();
    clear_logs();
    stuck_len = 20;
    push_byte(0, 8'h61, 1'b0); push_byte(0, 8'h62, 1'b1);
    push_byte(3, 8'h63, 1'b1);
    exp_pkt_start(3); exp_q.push_back(8'h63);
    exp_pkt_start(0); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    wait_pkts(2, 800);
    repeat (40) @(negedge clk);
    stuck_len = 1;
    checks++; if (pkt_cnt !== 2) begin failures++; $display("FAIL stuck_pkt_count got=%0d want=2", pkt_cnt); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= gnt_log.size() || gnt_log[i] !== exp_gnt[i]) begin
        failures++; $display("FAIL stuck_grant[%0d] got=%0d want=%0d", i, (i < gnt_log.size()) ? gnt_log[i] : 2'bxx, exp_gnt[i]);
      end
    end
    checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL stuck_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL stuck_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_header();
    clear_logs();
    push_byte(3, 8'h5A, 1'b1);
    exp_pkt_start(3); exp_q.push_back(8'h5A);
    wait_pkts(1, 300);
    checks++; if (pkt_cnt !== 1) begin failures++; $display("FAIL hdr_pkt_done got=%0d want=1", pkt_cnt); end
    checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL hdr_byte_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL hdr_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    clear_logs();
    push_byte(1, 8'h71, 1'b0); push_byte(1, 8'h72, 1'b0);
    push_byte(1, 8'h73, 1'b0); push_byte(1, 8'h74, 1'b1);
    while (rx_q.size() < 2 + HDR_N && c < 400) begin @(negedge clk); c++; end
    checks++; if (rx_q.size() < 2 + HDR_N) begin failures++; $display("FAIL rmid_progress got=%0d want=%0d", rx_q.size(), 2 + HDR_N); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rmid_tx got=%b/%h want=0/00", tx_en, tx_data); end
    checks++; if (grant_id !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_grant_busy got=%0d/%b want=0/0", grant_id, busy); end
    checks++; if (req_ready !== 4'b0000 || pkt_done !== 1'b0) begin failures++; $display("FAIL rmid_ready_pkt got=%b/%b want=0000/0", req_ready, pkt_done); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL rmid_state got=%0d want=0", state_dbg); end
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    push_byte(2, 8'h81, 1'b1);
    push_byte(0, 8'h82, 1'b1);
    exp_pkt_start(0); exp_q.push_back(8'h82);
    exp_pkt_start(2); exp_q.push_back(8'h81);
    wait_pkts(2, 600);
    checks++; if (pkt_cnt !== 2) begin failures++; $display("FAIL rmid_after_pkts got=%0d want=2", pkt_cnt); end
    checks++; if (gnt_log.size() < 1 || gnt_log[0] !== 2'd0) begin failures++; $display("FAIL rmid_first_grant got=%0d want=0", (gnt_log.size() > 0) ? gnt_log[0] : 2'bxx); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rmid_byte[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_stall();
    test_stuck_done();
    test_header();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
